alu_seq_display: RTL and testbench

Parametrised successor to the 4-bit ALU/display top. It integrates, as one single-clock block, the following:
- a step-enable generator (a one-cycle enable pulse, not a derived clock);
- a WIDTH-bit registered ALU with carry/zero/overflow flags and an accumulate mode;
- a multiplexed NUM_DIGITS hex display driver for the Basys3 common-anode 7-segment display.

It sits directly under the board top, between the switches/buttons and the seg/an pins.

---
 rtl/alu_seq_display.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_display.sv
// Registered WIDTH-bit ALU stepped by a slow enable pulse, with a multiplexed
// common-anode hex display of the result. Everything runs on one clock.
module alu_seq_display #(
  parameter int WIDTH      = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int STEP_HZ    = 5,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clk_100Mhz,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_a,
  input  logic [WIDTH-1:0]      data_b,
  input  logic [3:0]            alu_sel,
  input  logic                  acc_mode,
  input  logic                  hold,
  output logic [WIDTH-1:0]      result,
  output logic                  carry_flag,
  output logic                  zero_flag,
  output logic                  ovf_flag,
  output logic                  step_tick,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit
);

  localparam int STEP_DIV = CLK_HZ / STEP_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int STEP_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NIBBLES  = WIDTH / 4;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_ROL = 4'h8, OP_ROR = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB,
    OP_MUL = 4'hC, OP_CMP = 4'hD, OP_PSB = 4'hE, OP_PSA = 4'hF
  } aluOp_e;

  logic [STEP_W-1:0]     r_stepCnt;
  logic                  r_stepTick;
  logic [WIDTH-1:0]      r_result;
  logic                  r_carry, r_zero, r_ovf;
  logic [SCAN_W-1:0]     r_scanCnt;
  logic [IDX_W-1:0]      r_digitIdx;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_digit;

  logic [WIDTH-1:0]   w_opA, w_res, w_dec;
  logic               w_carry, w_ovf, w_blank;
  logic [WIDTH:0]     w_sum, w_diff, w_inc;
  logic [2*WIDTH-1:0] w_prod;
  logic [3:0]         w_nibble;
  logic [6:0]         w_hexSeg;

  // Tick is registered so the first pulse lands exactly STEP_DIV edges after reset.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      r_stepCnt  <= '0;
      r_stepTick <= 1'b0;
    end else if (r_stepCnt == STEP_W'(STEP_DIV - 1)) begin
      r_stepCnt  <= '0;
      r_stepTick <= 1'b1;
    end else begin
      r_stepCnt  <= r_stepCnt + STEP_W'(1);
      r_stepTick <= 1'b0;
    end
  end

  assign w_opA  = acc_mode ? r_result : data_a;
  assign w_sum  = {1'b0, w_opA} + {1'b0, data_b};
  assign w_diff = {1'b0, w_opA} - {1'b0, data_b};
  assign w_inc  = {1'b0, w_opA} + (WIDTH+1)'(1);
  assign w_dec  = w_opA - WIDTH'(1);
  assign w_prod = (2*WIDTH)'(w_opA) * (2*WIDTH)'(data_b);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (aluOp_e'(alu_sel))
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (w_opA[WIDTH-1] == data_b[WIDTH-1]) && (w_res[WIDTH-1] != w_opA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (w_opA[WIDTH-1] != data_b[WIDTH-1]) && (w_res[WIDTH-1] != w_opA[WIDTH-1]);
      end
      OP_AND: w_res = w_opA & data_b;
      OP_OR:  w_res = w_opA | data_b;
      OP_XOR: w_res = w_opA ^ data_b;
      OP_NOT: w_res = ~w_opA;
      OP_SHL: begin
        w_res   = {w_opA[WIDTH-2:0], 1'b0};
        w_carry = w_opA[WIDTH-1];
      end
      OP_SHR: begin
        w_res   = {1'b0, w_opA[WIDTH-1:1]};
        w_carry = w_opA[0];
      end
      OP_ROL: w_res = {w_opA[WIDTH-2:0], w_opA[WIDTH-1]};
      OP_ROR: w_res = {w_opA[0], w_opA[WIDTH-1:1]};
      OP_INC: begin
        w_res   = w_inc[WIDTH-1:0];
        w_carry = w_inc[WIDTH];
        w_ovf   = (w_opA == MAX_POS);
      end
      OP_DEC: begin
        w_res   = w_dec;
        w_carry = (w_opA == '0);
        w_ovf   = (w_opA == MIN_NEG);
      end
      OP_MUL: begin
        w_res   = w_prod[WIDTH-1:0];
        w_carry = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_CMP: begin
        w_res   = WIDTH'(w_opA < data_b);
        w_carry = (w_opA == data_b);
      end
      OP_PSB: w_res = data_b;
      OP_PSA: w_res = w_opA;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_stepTick && !hold) begin
      r_result <= w_res;
      r_carry  <= w_carry;
      r_zero   <= (w_res == '0);
      r_ovf    <= w_ovf;
    end
  end

  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      r_scanCnt  <= '0;
      r_digitIdx <= '0;
    end else if (r_scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scanCnt  <= '0;
      r_digitIdx <= (r_digitIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_digitIdx + IDX_W'(1);
    end else begin
      r_scanCnt  <= r_scanCnt + SCAN_W'(1);
    end
  end

  assign w_nibble = 4'(r_result >> (4 * r_digitIdx));
  assign w_blank  = (int'(r_digitIdx) >= NIBBLES);

  always_comb begin
    w_hexSeg = 7'h7F;
    case (w_nibble)
      4'h0: w_hexSeg = 7'h40;
      4'h1: w_hexSeg = 7'h79;
      4'h2: w_hexSeg = 7'h24;
      4'h3: w_hexSeg = 7'h30;
      4'h4: w_hexSeg = 7'h19;
      4'h5: w_hexSeg = 7'h12;
      4'h6: w_hexSeg = 7'h02;
      4'h7: w_hexSeg = 7'h78;
      4'h8: w_hexSeg = 7'h00;
      4'h9: w_hexSeg = 7'h10;
      4'hA: w_hexSeg = 7'h08;
      4'hB: w_hexSeg = 7'h03;
      4'hC: w_hexSeg = 7'h46;
      4'hD: w_hexSeg = 7'h21;
      4'hE: w_hexSeg = 7'h06;
      4'hF: w_hexSeg = 7'h0E;
      default: w_hexSeg = 7'h7F;
    endcase
  end

  // Digits beyond the result width stay blank but keep their anode in the scan.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      r_seg   <= 7'h7F;
      r_digit <= '1;
    end else begin
      r_seg   <= w_blank ? 7'h7F : w_hexSeg;
      r_digit <= ~(NUM_DIGITS'(1) << r_digitIdx);
    end
  end

  assign result     = r_result;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign ovf_flag   = r_ovf;
  assign step_tick  = r_stepTick;
  assign seg        = r_seg;
  assign digit      = r_digit;

endmodule

// File: tb/tb_alu_seq_display.sv
// Directed bench for alu_seq_display: STEP_DIV=10, SCAN_DIV=2, WIDTH=8, 4 digits.
module tb_alu_seq_display;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] dataA, dataB;
  logic [3:0] aluSel;
  logic       accMode, hold;
  logic [7:0] result;
  logic       carryFlag, zeroFlag, ovfFlag, stepTick;
  logic [6:0] seg;
  logic [3:0] digit;

  int checks = 0;
  int errors = 0;

  alu_seq_display #(
    .WIDTH(8), .CLK_HZ(100), .STEP_HZ(10), .SCAN_HZ(50), .NUM_DIGITS(4)
  ) dut (
    .clk_100Mhz(clock), .reset(reset), .data_a(dataA), .data_b(dataB),
    .alu_sel(aluSel), .acc_mode(accMode), .hold(hold), .result(result),
    .carry_flag(carryFlag), .zero_flag(zeroFlag), .ovf_flag(ovfFlag),
    .step_tick(stepTick), .seg(seg), .digit(digit)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are never changed in a tick cycle here, so each update uses them exactly once.
  task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                               input logic acc, input logic hld);
    if (stepTick) @(negedge clock);
    aluSel  = sel;
    dataA   = a;
    dataB   = b;
    accMode = acc;
    hold    = hld;
  endtask

  task automatic waitTick();
    logic found = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (stepTick) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("tickWait", 32'(found), 32'd1);
  endtask

  task automatic waitUpdate();
    waitTick();
    @(negedge clock);
  endtask

  task automatic checkAlu(input string tag, input logic [7:0] r, input logic c, input logic z, input logic v);
    checkOutput({tag, "_result"}, 32'(result), 32'(r));
    checkOutput({tag, "_carry"}, 32'(carryFlag), 32'(c));
    checkOutput({tag, "_zero"}, 32'(zeroFlag), 32'(z));
    checkOutput({tag, "_ovf"}, 32'(ovfFlag), 32'(v));
  endtask

  task automatic runOp(input string tag, input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic c, input logic z, input logic v);
    applyStimulus(sel, a, b, 1'b0, 1'b0);
    waitUpdate();
    checkAlu(tag, r, c, z, v);
  endtask

  task automatic checkDigit(input string tag, input int idx, input logic [6:0] expSeg);
    logic [3:0] anode;
    logic       found = 1'b0;
    anode = ~(4'b0001 << idx);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (digit === anode) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_anode"}, 32'(found), 32'd1);
    checkOutput({tag, "_seg"}, 32'(seg), 32'(expSeg));
  endtask

  initial begin
    reset = 1'b1;
    dataA = 8'h00; dataB = 8'h00; aluSel = 4'h0; accMode = 1'b0; hold = 1'b0;

    repeat (3) @(negedge clock);
    checkAlu("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_tick", 32'(stepTick), 32'd0);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    checkOutput("reset_digit", 32'(digit), 32'hF);

    reset = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      checkOutput($sformatf("tick_k%0d", k), 32'(stepTick), 32'((k == 10) || (k == 20)));
    end

    runOp("addCarry", 4'h0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    checkDigit("d0_10", 0, 7'h40);
    checkDigit("d1_10", 1, 7'h79);
    checkDigit("d2_blank", 2, 7'h7F);
    checkDigit("d3_blank", 3, 7'h7F);

    runOp("addOvf", 4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    runOp("subBorrow", 4'h1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    checkDigit("d0_FF", 0, 7'h0E);
    checkDigit("d1_FF", 1, 7'h0E);

    runOp("passFE", 4'hF, 8'hFE, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'hA, 8'h00, 8'h00, 1'b1, 1'b0);
    waitUpdate();
    checkAlu("accInc1", 8'hFF, 1'b0, 1'b0, 1'b0);
    waitUpdate();
    checkAlu("accInc2", 8'h00, 1'b1, 1'b1, 1'b0);

    applyStimulus(4'hF, 8'h55, 8'h00, 1'b0, 1'b1);
    waitUpdate();
    checkAlu("hold1", 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'hF, 8'hAA, 8'h00, 1'b0, 1'b1);
    waitUpdate();
    checkAlu("hold2", 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'hF, 8'hAA, 8'h00, 1'b0, 1'b0);
    waitUpdate();
    checkAlu("holdRelease", 8'hAA, 1'b0, 1'b0, 1'b0);

    waitTick();
    hold  = 1'b1;
    dataA = 8'h11;
    @(negedge clock);
    checkAlu("holdOnTick", 8'hAA, 1'b0, 1'b0, 1'b0);

    runOp("mulHigh", 4'hC, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkAlu("asyncReset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("asyncReset_seg", 32'(seg), 32'h7F);
    checkOutput("asyncReset_digit", 32'(digit), 32'hF);
    @(negedge clock);
    reset = 1'b0;

    runOp("subOvf", 4'h1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    runOp("and", 4'h2, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0);
    runOp("or", 4'h3, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0);
    runOp("xor", 4'h4, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0, 1'b0);
    runOp("not", 4'h5, 8'hCC, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0);
    runOp("shl", 4'h6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    runOp("shr", 4'h7, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
    runOp("rol", 4'h8, 8'h81, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    runOp("ror", 4'h9, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0);
    runOp("incOvf", 4'hA, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
    runOp("decOvf", 4'hB, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1);
    runOp("decBorrow", 4'hB, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    runOp("mulLow", 4'hC, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b0);
    runOp("cmpLess", 4'hD, 8'h05, 8'h09, 8'h01, 1'b0, 1'b0, 1'b0);
    runOp("cmpEqual", 4'hD, 8'h09, 8'h09, 8'h00, 1'b1, 1'b1, 1'b0);
    runOp("passB", 4'hE, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
    hold = 1'b1;
    checkDigit("d0_3C", 0, 7'h46);
    checkDigit("d1_3C", 1, 7'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
